// File: rtl/pic_pkg.sv
// Shared definitions for the 8259 interrupt sequencer: FSM encodings, OCW2 command
// codes and the circular priority search used by the resolver.
package pic_pkg;

  localparam int NUM_IR = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_PEND  = 3'd1;
  localparam state_t ST_ACK1  = 3'd2;
  localparam state_t ST_WAIT2 = 3'd3;
  localparam state_t ST_ACK2  = 3'd4;

  // OCW2 {R, SL, EOI} field values
  localparam logic [2:0] EOI_NS       = 3'b001;
  localparam logic [2:0] EOI_SP       = 3'b011;
  localparam logic [2:0] ROT_NS       = 3'b101;
  localparam logic [2:0] ROT_SP       = 3'b111;
  localparam logic [2:0] SET_PRI      = 3'b110;
  localparam logic [2:0] ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] ROT_AEOI_CLR = 3'b000;

  // Returns {valid, level}; level lowest+1 is the highest priority, scanning circularly.
  function automatic logic [3:0] highest_set(input logic [NUM_IR-1:0] vec,
                                             input logic [2:0] lowest);
    logic [3:0] res;
    logic [2:0] lvl;
    res = 4'b0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      lvl = lowest + 3'(i) + 3'd1;
      if (vec[lvl]) res = {1'b1, lvl};
    end
    return res;
  endfunction

endpackage

// File: rtl/interrupt_sequencer_priority_resolver.sv
// Combinational circular find-first over the eight request levels.
module priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] vec,
  input  logic [2:0]        lowest,
  output logic              valid,
  output logic [2:0]        level
);

  logic [3:0] hit;

  assign hit   = highest_set(vec, lowest);
  assign valid = hit[3];
  assign level = hit[2:0];

endmodule

// File: rtl/interrupt_sequencer.sv
// 8259 interrupt sequencer: IRR capture, nested/rotating priority, INTA handshake,
// ISR maintenance and OCW2 EOI/rotation commands.
module interrupt_sequencer
  import pic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IR-1:0] IR,
  input  logic              LEVEL,
  input  logic [NUM_IR-1:0] interrupt_mask,
  input  logic              AEOI,
  input  logic              INTA_,
  input  logic [7:0]        OCW2,
  input  logic              OCW2_WR,
  output logic              INT,
  output logic [2:0]        IR_NUM,
  output logic              VEC_EN,
  output logic [1:0]        INTA_COUNT,
  output logic [NUM_IR-1:0] IRR,
  output logic [NUM_IR-1:0] ISR,
  output state_t            state_dbg
);

  state_t            state, next_state;
  logic [NUM_IR-1:0] ir_d;
  logic              inta_d;
  logic [2:0]        lowest;
  logic              rotate_aeoi;

  logic              cand_valid, isr_valid;
  logic [2:0]        cand_lvl, isr_lvl, cand_rank, isr_rank;
  logic              req, inta_fall, inta_rise;
  logic              enter_ack1, ack_real, exit_ack2;
  logic [NUM_IR-1:0] ack_set, eoi_clr, aeoi_clr, irr_base;
  logic [2:0]        cmd;

  priority_resolver u_irr_res (
    .vec(IRR & ~interrupt_mask), .lowest(lowest), .valid(cand_valid), .level(cand_lvl)
  );
  priority_resolver u_isr_res (
    .vec(ISR), .lowest(lowest), .valid(isr_valid), .level(isr_lvl)
  );

  // Rank 0 is the highest priority level (lowest + 1).
  assign cand_rank = cand_lvl - lowest - 3'd1;
  assign isr_rank  = isr_lvl - lowest - 3'd1;
  assign req       = cand_valid && (!isr_valid || (cand_rank < isr_rank));
  assign inta_fall = inta_d && !INTA_;
  assign inta_rise = !inta_d && INTA_;
  assign cmd       = OCW2[7:5];

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (inta_fall) next_state = ST_ACK1;
                else if (req)  next_state = ST_PEND;
      ST_PEND:  if (inta_fall) next_state = ST_ACK1;
                else if (!req) next_state = ST_IDLE;
      ST_ACK1:  if (inta_rise) next_state = ST_WAIT2;
      ST_WAIT2: if (inta_fall) next_state = ST_ACK2;
      ST_ACK2:  if (inta_rise) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // A falling edge taken from IDLE, or with no candidate left, is spurious.
  assign enter_ack1 = inta_fall && (state == ST_IDLE || state == ST_PEND);
  assign ack_real   = inta_fall && (state == ST_PEND) && cand_valid;
  assign exit_ack2  = inta_rise && (state == ST_ACK2);
  assign ack_set    = ack_real ? (NUM_IR'(1) << cand_lvl) : '0;
  assign aeoi_clr   = (exit_ack2 && AEOI) ? (NUM_IR'(1) << IR_NUM) : '0;
  assign irr_base   = LEVEL ? IR : (IRR | (IR & ~ir_d));

  always_comb begin
    eoi_clr = '0;
    if (OCW2_WR) begin
      case (cmd)
        EOI_NS, ROT_NS: if (isr_valid) eoi_clr = NUM_IR'(1) << isr_lvl;
        EOI_SP, ROT_SP: eoi_clr = NUM_IR'(1) << OCW2[2:0];
        default:        eoi_clr = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ir_d        <= '0;
      inta_d      <= 1'b1;
      lowest      <= 3'd7;
      rotate_aeoi <= 1'b0;
      IRR         <= '0;
      ISR         <= '0;
      IR_NUM      <= 3'd0;
      INTA_COUNT  <= 2'd0;
    end else begin
      state  <= next_state;
      ir_d   <= IR;
      inta_d <= INTA_;
      IRR    <= irr_base & ~ack_set;
      // A set from the acknowledge wins over a clear on the same bit.
      ISR    <= (ISR & ~(eoi_clr | aeoi_clr)) | ack_set;

      if (enter_ack1) begin
        IR_NUM     <= ack_real ? cand_lvl : 3'd7;
        INTA_COUNT <= 2'd1;
      end else if (state == ST_WAIT2 && inta_fall) begin
        INTA_COUNT <= 2'd2;
      end else if (exit_ack2) begin
        INTA_COUNT <= 2'd0;
      end

      if (exit_ack2 && AEOI && rotate_aeoi) lowest <= IR_NUM;

      if (OCW2_WR) begin
        case (cmd)
          ROT_NS:         if (isr_valid) lowest <= isr_lvl;
          ROT_SP, SET_PRI: lowest <= OCW2[2:0];
          ROT_AEOI_SET:   rotate_aeoi <= 1'b1;
          ROT_AEOI_CLR:   rotate_aeoi <= 1'b0;
          default:        ;
        endcase
      end
    end
  end

  assign INT       = (state == ST_PEND);
  assign VEC_EN    = (state == ST_ACK2);
  assign state_dbg = state;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: each task drives one scenario and checks inline.
module tb_interrupt_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] IR = 8'h00;
  logic       LEVEL = 1'b0;
  logic [7:0] interrupt_mask = 8'h00;
  logic       AEOI = 1'b0;
  logic       INTA_ = 1'b1;
  logic [7:0] OCW2 = 8'h00;
  logic       OCW2_WR = 1'b0;
  logic       INT;
  logic [2:0] IR_NUM;
  logic       VEC_EN;
  logic [1:0] INTA_COUNT;
  logic [7:0] IRR;
  logic [7:0] ISR;
  logic [2:0] state_dbg;

  int tests = 0;
  int fails = 0;

  interrupt_sequencer dut (
    .clk(clk), .reset(reset), .IR(IR), .LEVEL(LEVEL), .interrupt_mask(interrupt_mask),
    .AEOI(AEOI), .INTA_(INTA_), .OCW2(OCW2), .OCW2_WR(OCW2_WR), .INT(INT),
    .IR_NUM(IR_NUM), .VEC_EN(VEC_EN), .INTA_COUNT(INTA_COUNT), .IRR(IRR), .ISR(ISR),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_ocw2(input logic [7:0] b);
    OCW2 = b;
    OCW2_WR = 1'b1;
    tick();
    OCW2_WR = 1'b0;
    OCW2 = 8'h00;
  endtask

  task automatic pulse_ir(input logic [7:0] v);
    IR = v;
    tick();
    IR = 8'h00;
  endtask

  task automatic inta(input logic v);
    INTA_ = v;
    tick();
  endtask

  task automatic full_ack();
    inta(1'b0); inta(1'b1); inta(1'b0); inta(1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    tests++; if (INT !== 1'b0) begin fails++; $display("FAIL reset_int got %b exp 0", INT); end
    tests++; if (IR_NUM !== 3'd0) begin fails++; $display("FAIL reset_irnum got %0d exp 0", IR_NUM); end
    tests++; if (VEC_EN !== 1'b0) begin fails++; $display("FAIL reset_vecen got %b exp 0", VEC_EN); end
    tests++; if (INTA_COUNT !== 2'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", INTA_COUNT); end
    tests++; if (IRR !== 8'h00 || ISR !== 8'h00) begin fails++; $display("FAIL reset_regs got irr=%h isr=%h exp 00/00", IRR, ISR); end
    tests++; if (state_dbg !== 3'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
    reset = 1'b0;
  endtask

  task automatic test_edge_ack();
    IR = 8'h08;
    tick();
    tests++; if (IRR !== 8'h08) begin fails++; $display("FAIL edge_irr got %h exp 08", IRR); end
    tests++; if (INT !== 1'b0) begin fails++; $display("FAIL edge_int_early got %b exp 0", INT); end
    IR = 8'h00;
    tick();
    tests++; if (INT !== 1'b1) begin fails++; $display("FAIL edge_int got %b exp 1", INT); end
    inta(1'b0);
    tests++; if (IR_NUM !== 3'd3 || ISR !== 8'h08 || IRR !== 8'h00) begin fails++; $display("FAIL ack1_regs got num=%0d isr=%h irr=%h exp 3/08/00", IR_NUM, ISR, IRR); end
    tests++; if (INTA_COUNT !== 2'd1 || INT !== 1'b0) begin fails++; $display("FAIL ack1_cnt got cnt=%0d int=%b exp 1/0", INTA_COUNT, INT); end
    inta(1'b1);
    tests++; if (VEC_EN !== 1'b0) begin fails++; $display("FAIL wait2_vecen got %b exp 0", VEC_EN); end
    inta(1'b0);
    tests++; if (INTA_COUNT !== 2'd2 || VEC_EN !== 1'b1) begin fails++; $display("FAIL ack2 got cnt=%0d vec=%b exp 2/1", INTA_COUNT, VEC_EN); end
    inta(1'b1);
    tests++; if (INTA_COUNT !== 2'd0 || VEC_EN !== 1'b0 || ISR !== 8'h08) begin fails++; $display("FAIL ack_done got cnt=%0d vec=%b isr=%h exp 0/0/08", INTA_COUNT, VEC_EN, ISR); end
    wr_ocw2(8'h20);
    tests++; if (ISR !== 8'h00) begin fails++; $display("FAIL ns_eoi got isr=%h exp 00", ISR); end
    wr_ocw2(8'h20);
    tests++; if (ISR !== 8'h00 || INT !== 1'b0) begin fails++; $display("FAIL ns_eoi_empty got isr=%h int=%b exp 00/0", ISR, INT); end
  endtask

  task automatic test_nesting();
    pulse_ir(8'h20); tick(); full_ack();
    tests++; if (ISR !== 8'h20) begin fails++; $display("FAIL nest_isr5 got %h exp 20", ISR); end
    pulse_ir(8'h04); tick();
    tests++; if (INT !== 1'b1) begin fails++; $display("FAIL nest_int_ir2 got %b exp 1", INT); end
    full_ack();
    tests++; if (ISR !== 8'h24 || IR_NUM !== 3'd2) begin fails++; $display("FAIL nest_ack2 got isr=%h num=%0d exp 24/2", ISR, IR_NUM); end
    wr_ocw2(8'h20);
    tests++; if (ISR !== 8'h20) begin fails++; $display("FAIL nest_eoi got isr=%h exp 20", ISR); end
    pulse_ir(8'h40); tick(); tick();
    tests++; if (INT !== 1'b0 || IRR !== 8'h40) begin fails++; $display("FAIL nest_block6 got int=%b irr=%h exp 0/40", INT, IRR); end
    wr_ocw2(8'h20);
    tests++; if (ISR !== 8'h00) begin fails++; $display("FAIL nest_eoi5 got isr=%h exp 00", ISR); end
    tick();
    tests++; if (INT !== 1'b1) begin fails++; $display("FAIL nest_int6 got %b exp 1", INT); end
    full_ack();
    tests++; if (IR_NUM !== 3'd6 || ISR !== 8'h40) begin fails++; $display("FAIL nest_ack6 got num=%0d isr=%h exp 6/40", IR_NUM, ISR); end
    wr_ocw2(8'h66);
    tests++; if (ISR !== 8'h00) begin fails++; $display("FAIL sp_eoi got isr=%h exp 00", ISR); end
  endtask

  task automatic test_rotation();
    wr_ocw2(8'hC4);
    pulse_ir(8'h22); tick();
    tests++; if (INT !== 1'b1) begin fails++; $display("FAIL rot_int got %b exp 1", INT); end
    full_ack();
    tests++; if (IR_NUM !== 3'd5 || ISR !== 8'h20 || IRR !== 8'h02) begin fails++; $display("FAIL rot_first got num=%0d isr=%h irr=%h exp 5/20/02", IR_NUM, ISR, IRR); end
    wr_ocw2(8'hA0);
    tests++; if (ISR !== 8'h00) begin fails++; $display("FAIL rot_eoi got isr=%h exp 00", ISR); end
    tick(); full_ack();
    tests++; if (IR_NUM !== 3'd1 || ISR !== 8'h02) begin fails++; $display("FAIL rot_second got num=%0d isr=%h exp 1/02", IR_NUM, ISR); end
    wr_ocw2(8'h61);
    wr_ocw2(8'hC7);
    tests++; if (ISR !== 8'h00 || IRR !== 8'h00) begin fails++; $display("FAIL rot_clean got isr=%h irr=%h exp 00/00", ISR, IRR); end
  endtask

  task automatic test_aeoi();
    AEOI = 1'b1;
    wr_ocw2(8'h80);
    pulse_ir(8'h04); tick();
    inta(1'b0); inta(1'b1); inta(1'b0);
    tests++; if (ISR !== 8'h04) begin fails++; $display("FAIL aeoi_during got isr=%h exp 04", ISR); end
    inta(1'b1);
    tests++; if (ISR !== 8'h00) begin fails++; $display("FAIL aeoi_after got isr=%h exp 00", ISR); end
    // lowest is now 2, so IR3 outranks IR2
    pulse_ir(8'h0C); tick(); full_ack();
    tests++; if (IR_NUM !== 3'd3 || ISR !== 8'h00 || IRR !== 8'h04) begin fails++; $display("FAIL aeoi_rot got num=%0d isr=%h irr=%h exp 3/00/04", IR_NUM, ISR, IRR); end
    tick(); full_ack();
    tests++; if (IR_NUM !== 3'd2 || IRR !== 8'h00) begin fails++; $display("FAIL aeoi_next got num=%0d irr=%h exp 2/00", IR_NUM, IRR); end
    wr_ocw2(8'h00);
    AEOI = 1'b0;
    wr_ocw2(8'hC7);
  endtask

  task automatic test_mask();
    interrupt_mask = 8'h01;
    pulse_ir(8'h01); tick(); tick();
    tests++; if (INT !== 1'b0 || IRR !== 8'h01) begin fails++; $display("FAIL mask_hold got int=%b irr=%h exp 0/01", INT, IRR); end
    interrupt_mask = 8'h00;
    tick();
    tests++; if (INT !== 1'b1) begin fails++; $display("FAIL mask_open got %b exp 1", INT); end
    interrupt_mask = 8'h01;
    tick();
    tests++; if (INT !== 1'b0) begin fails++; $display("FAIL mask_close got %b exp 0", INT); end
    interrupt_mask = 8'h00;
    tick(); full_ack();
    tests++; if (IR_NUM !== 3'd0 || ISR !== 8'h01) begin fails++; $display("FAIL mask_ack got num=%0d isr=%h exp 0/01", IR_NUM, ISR); end
    wr_ocw2(8'h20);
  endtask

  task automatic test_level_spurious();
    LEVEL = 1'b1;
    IR = 8'h10;
    tick();
    tests++; if (IRR !== 8'h10) begin fails++; $display("FAIL lvl_irr got %h exp 10", IRR); end
    tick();
    tests++; if (INT !== 1'b1) begin fails++; $display("FAIL lvl_int got %b exp 1", INT); end
    IR = 8'h00;
    tick();
    tests++; if (IRR !== 8'h00) begin fails++; $display("FAIL lvl_drop got irr=%h exp 00", IRR); end
    inta(1'b0);
    tests++; if (IR_NUM !== 3'd7 || ISR !== 8'h00 || INTA_COUNT !== 2'd1) begin fails++; $display("FAIL lvl_spur got num=%0d isr=%h cnt=%0d exp 7/00/1", IR_NUM, ISR, INTA_COUNT); end
    inta(1'b1); inta(1'b0); inta(1'b1);
    tests++; if (INTA_COUNT !== 2'd0 || ISR !== 8'h00) begin fails++; $display("FAIL lvl_done got cnt=%0d isr=%h exp 0/00", INTA_COUNT, ISR); end
    LEVEL = 1'b0;
  endtask

  task automatic test_reset_midack();
    pulse_ir(8'h08); tick();
    inta(1'b0); inta(1'b1);
    tests++; if (state_dbg !== 3'd3 || ISR !== 8'h08) begin fails++; $display("FAIL mid_wait2 got st=%0d isr=%h exp 3/08", state_dbg, ISR); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (INT !== 1'b0 || IR_NUM !== 3'd0 || VEC_EN !== 1'b0 || INTA_COUNT !== 2'd0) begin fails++; $display("FAIL mid_reset_out got int=%b num=%0d vec=%b cnt=%0d exp 0/0/0/0", INT, IR_NUM, VEC_EN, INTA_COUNT); end
    tests++; if (IRR !== 8'h00 || ISR !== 8'h00 || state_dbg !== 3'd0) begin fails++; $display("FAIL mid_reset_regs got irr=%h isr=%h st=%0d exp 00/00/0", IRR, ISR, state_dbg); end
    inta(1'b0);
    tests++; if (IR_NUM !== 3'd7 || ISR !== 8'h00) begin fails++; $display("FAIL mid_spur got num=%0d isr=%h exp 7/00", IR_NUM, ISR); end
    inta(1'b1); inta(1'b0); inta(1'b1);
    tests++; if (ISR !== 8'h00 || state_dbg !== 3'd0) begin fails++; $display("FAIL mid_after got isr=%h st=%0d exp 00/0", ISR, state_dbg); end
  endtask

  initial begin
    test_reset();
    test_edge_ack();
    test_nesting();
    test_rotation();
    test_aeoi();
    test_mask();
    test_level_spurious();
    test_reset_midack();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
